// File: rtl/axis_pixel_tracker_if.sv
// Bus bundle for axis_pixel_tracker: incoming video stream, tagged outgoing
// stream and error status/clear. The tracker sits on the slave modport.
interface axis_pixel_tracker_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tuser;
  logic              s_axis_tlast;

  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [15:0]       m_x;
  logic [15:0]       m_y;
  logic [15:0]       m_frame;
  logic              m_eof;

  logic              clear_err;
  logic [3:0]        err_status;
  logic [15:0]       err_count;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    input  m_tready, clear_err,
    output s_axis_tready,
    output m_tdata, m_tvalid, m_x, m_y, m_frame, m_eof,
    output err_status, err_count
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    output m_tready, clear_err,
    input  s_axis_tready,
    input  m_tdata, m_tvalid, m_x, m_y, m_frame, m_eof,
    input  err_status, err_count
  );
endinterface

// File: rtl/axis_pixel_tracker.sv
// Tags each accepted video beat with (x, y, frame), checks SOF/EOL framing
// against the configured image size and keeps sticky error status.
//   state    | meaning
//   WAIT_SOF | out of sync, dropping beats until one carries tuser
//   ACTIVE   | inside a frame, x/y counters track the next beat
module axis_pixel_tracker #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 24
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_pixel_tracker_if.slave  bus
);

  localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

  typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            r_state;
  logic [15:0]       r_x_cnt;
  logic [15:0]       r_y_cnt;
  logic [15:0]       r_frame_cnt;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;
  logic [15:0]       r_x;
  logic [15:0]       r_y;
  logic [15:0]       r_frame;
  logic              r_eof;
  logic [3:0]        r_err_status;
  logic [15:0]       r_err_count;

  logic              w_ready;
  logic              w_accept;
  logic              w_x_last;
  logic              w_y_last;
  logic              w_line_end;
  logic              w_last_pix;
  logic [15:0]       w_frame_inc;
  logic [3:0]        w_err;

  // Ready is forced low during reset so nothing is accepted while aresetn is low.
  assign w_ready     = aresetn && (!r_tvalid || bus.m_tready);
  assign w_accept    = bus.s_axis_tvalid && w_ready;
  assign w_x_last    = (r_x_cnt == X_LAST);
  assign w_y_last    = (r_y_cnt == Y_LAST);
  assign w_line_end  = bus.s_axis_tlast || w_x_last;
  assign w_last_pix  = w_line_end && w_y_last;
  assign w_frame_inc = r_frame_cnt + 16'd1;

  always_comb begin
    w_err = 4'b0000;
    if (w_accept) begin
      if (r_state == WAIT_SOF) begin
        w_err[0] = !bus.s_axis_tuser;
      end else if (bus.s_axis_tuser) begin
        w_err[1] = 1'b1;
      end else begin
        w_err[2] = bus.s_axis_tlast && !w_x_last;
        w_err[3] = !bus.s_axis_tlast && w_x_last;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= WAIT_SOF;
      r_x_cnt     <= '0;
      r_y_cnt     <= '0;
      r_frame_cnt <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_frame     <= '0;
      r_eof       <= 1'b0;
    end else begin
      if (w_ready) r_tvalid <= 1'b0;
      if (w_accept) begin
        if (r_state == WAIT_SOF) begin
          if (bus.s_axis_tuser) begin
            r_tvalid <= 1'b1;
            r_tdata  <= bus.s_axis_tdata;
            r_x      <= '0;
            r_y      <= '0;
            r_frame  <= r_frame_cnt;
            r_eof    <= 1'b0;
            r_x_cnt  <= 16'd1;
            r_y_cnt  <= '0;
            r_state  <= ACTIVE;
          end
        end else if (bus.s_axis_tuser) begin
          // Early SOF restarts the frame on this beat; EOL checks do not apply.
          r_tvalid    <= 1'b1;
          r_tdata     <= bus.s_axis_tdata;
          r_x         <= '0;
          r_y         <= '0;
          r_frame     <= w_frame_inc;
          r_eof       <= 1'b0;
          r_frame_cnt <= w_frame_inc;
          r_x_cnt     <= 16'd1;
          r_y_cnt     <= '0;
        end else begin
          r_tvalid <= 1'b1;
          r_tdata  <= bus.s_axis_tdata;
          r_x      <= r_x_cnt;
          r_y      <= r_y_cnt;
          r_frame  <= r_frame_cnt;
          r_eof    <= w_last_pix;
          if (w_line_end) begin
            r_x_cnt <= '0;
            if (w_y_last) begin
              r_y_cnt     <= '0;
              r_frame_cnt <= w_frame_inc;
              r_state     <= WAIT_SOF;
            end else begin
              r_y_cnt <= r_y_cnt + 16'd1;
            end
          end else begin
            r_x_cnt <= r_x_cnt + 16'd1;
          end
        end
      end
    end
  end

  // A clear coinciding with an errored beat keeps that beat's error.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_err_status <= '0;
      r_err_count  <= '0;
    end else if (bus.clear_err) begin
      r_err_status <= w_err;
      r_err_count  <= {15'd0, |w_err};
    end else begin
      r_err_status <= r_err_status | w_err;
      if ((|w_err) && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
    end
  end

  assign bus.s_axis_tready = w_ready;
  assign bus.m_tdata       = r_tdata;
  assign bus.m_tvalid      = r_tvalid;
  assign bus.m_x           = r_x;
  assign bus.m_y           = r_y;
  assign bus.m_frame       = r_frame;
  assign bus.m_eof         = r_eof;
  assign bus.err_status    = r_err_status;
  assign bus.err_count     = r_err_count;

endmodule

// File: doc/axis_pixel_tracker.md
# axis_pixel_tracker

- Sits between the DUT AXI4-Stream video output and the pixel scoreboard.
- Registers each accepted beat and tags it with pixel coordinates (x, y) and a frame index, which the scoreboard uses to look up the reference pixel.
- Checks SOF/EOL framing against the configured image size and resynchronises on framing errors.
- Keeps sticky error status and a saturating error counter.

## Interface
- IMG_WIDTH, 640, active pixels per line (≥2)
- IMG_HEIGHT, 480, lines per frame (≥2)
- DATA_W, 24, pixel word width (OUT_NPIX*8)
- aclk  in  1  clock, all logic rising-edge
- aresetn  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  DATA_W  input pixel
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input ready
- s_axis_tuser  in  1  start of frame (SOF)
- s_axis_tlast  in  1  end of line (EOL)
- m_tdata  out  DATA_W  registered pixel
- m_tvalid  out  1  output beat valid
- m_tready  in  1  consumer ready
- m_x  out  16  column of m_tdata
- m_y  out  16  line of m_tdata
- m_frame  out  16  frame index of m_tdata
- m_eof  out  1  beat is pixel (IMG_WIDTH-1, IMG_HEIGHT-1)
- clear_err  in  1  sync pulse, clears err_status and err_count
- err_status  out  4  sticky: [0] SOF missing, [1] SOF early, [2] EOL early, [3] EOL late
- err_count  out  16  saturating count of error events

## Operation
- Input beat is accepted when s_axis_tvalid && s_axis_tready.
- s_axis_tready = aresetn && (!m_tvalid || m_tready). Single output register, full throughput.
- Internal counters: x_cnt, y_cnt, frame_cnt (16-bit, wraps 0xFFFF→0). FSM states: WAIT_SOF, ACTIVE.
- **WAIT_SOF, accepted beat without tuser:** beat discarded (not forwarded). Sets err[0]. err_count += 1. Stays in WAIT_SOF.
- **WAIT_SOF, accepted beat with tuser:** forwarded with x=0, y=0, m_frame=frame_cnt. Next x_cnt=1. Go to ACTIVE.
- **ACTIVE, beat with tuser (SOF early):**
  - Sets err[1].
  - frame_cnt += 1, and the beat is forwarded as x=0, y=0 of the new frame.
  - Next x_cnt=1, y_cnt=0.
  - EOL checks are not applied to this beat.
- **ACTIVE, normal beat:** forwarded with x=x_cnt, y=y_cnt.
  - tlast && x_cnt≠IMG_WIDTH-1: sets err[2] (EOL early). Line ends: x_cnt←0, y_cnt+1.
  - !tlast && x_cnt==IMG_WIDTH-1: sets err[3] (EOL late). Line ends anyway: x_cnt←0, y_cnt+1.
  - Otherwise, x_cnt increments; the line ends only at x_cnt==IMG_WIDTH-1 with tlast.
- **Last pixel:** when a line ends with y_cnt==IMG_HEIGHT-1, the beat is forwarded with m_eof=1. Then frame_cnt += 1, x_cnt=y_cnt=0, go to WAIT_SOF.
- **Multiple errors on one beat:** all applicable flags are set; err_count increments by 1 per errored beat.
- **err_count** saturates at 0xFFFF.
- **clear_err:** zeroes err_status and err_count. If an error occurs in the same cycle, the new error is recorded after the clear (result: that flag=1, count=1).

## Timing
- Latency: accepted beat appears on m_* on the next cycle.
- m_* hold stable while m_tvalid && !m_tready.
- Input accept and output drain can occur in the same cycle.
- Reset values: m_tvalid=0, m_tdata=0, m_x=0, m_y=0, m_frame=0, m_eof=0, err_status=0, err_count=0, frame_cnt=0, state=WAIT_SOF.
- s_axis_tready=0 while aresetn low.
- Reset asserted mid-frame aborts the frame immediately. Any pending output beat is dropped.
- First cycle after reset release: s_axis_tready=1.
- err_status and err_count update on the cycle after the errored beat is accepted, i.e. aligned with that beat on m_*.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=2.
- **Clean frames:** two clean frames, m_tready=1 → 16 output beats. Coordinates (0,0)…(3,1), m_frame 0 then 1. m_eof on beats 8 and 16. err_status=0.
- **Backpressure:** m_tready toggling 1010… with continuous input → no beat lost or duplicated. m_* stable while stalled. s_axis_tready low exactly when m_tvalid && !m_tready.
- **Missing SOF:** 3 beats without tuser after reset, then a clean frame → first 3 beats dropped. err_status=4'b0001, err_count=3. Frame forwarded as frame 0.
- **Framing errors:**
  - tlast at x=2 on line 0 → err[2]. Next beat is tagged (0,1).
  - Separately, no tlast at x=3 → err[3] and wrap to (0,1).
  - tuser at (1,1) → err[1]. Beat tagged (0,0), m_frame incremented.
- **Clear vs. error collision:** clear_err in the same cycle as an errored beat's update → err_count=1, only the new flag set. Also force err_count to 0xFFFF, inject an error → stays 0xFFFF.
- **Reset mid-frame:** assert aresetn low mid-frame → all outputs return to reset values immediately. After release, a clean frame is tagged m_frame=0 starting at (0,0).
